capsense_prs_pulse_gen: RTL and testbench

Precharge/sense-clock generator for the CapSense CSD measurement channel. It divides the component clock by a programmable prescaler and produces either a fixed-frequency or a pseudo-random (PRS) sense clock for the sensor switches. It also produces a one-cycle `pulse` strobe, aligned to each sense-clock rising edge, which drives the measurement channel's comparator sampling and window/counter stepping. It sits directly upstream of the measurement channel, on the same `clock`.

---
 rtl/capsense_prs_pulse_gen_if.sv | 22 ++
 rtl/capsense_prs_pulse_gen.sv | 72 +++++++
 tb/tb_capsense_prs_pulse_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/capsense_prs_pulse_gen_if.sv
// Control and status bundle for the CSD sense-clock generator.
// master = firmware/channel side, slave = generator.
interface capsense_prs_if #(
    parameter int unsigned PrsWidth = 16
);
    logic                enable;
    logic                mode;
    logic [7:0]          div_val;
    logic                sense_clk;
    logic                pulse;
    logic [PrsWidth-1:0] prs_state;

    modport master (
        output enable, mode, div_val,
        input  sense_clk, pulse, prs_state
    );

    modport slave (
        input  enable, mode, div_val,
        output sense_clk, pulse, prs_state
    );
endinterface

// File: rtl/capsense_prs_pulse_gen.sv
// CSD precharge/sense-clock generator: prescaler, fixed or PRS sense clock,
// and a one-cycle strobe on every sense-clock rising edge.
module capsense_prs_pulse_gen #(
    parameter int unsigned PrsWidth   = 16,
    parameter logic [15:0] Polynomial = 16'hA011,
    parameter logic [15:0] Seed       = 16'h0001
) (
    input logic           clock,
    input logic           reset,
    capsense_prs_if.slave bus
);
    localparam logic [PrsWidth-1:0] Poly    = Polynomial[PrsWidth-1:0];
    localparam logic [PrsWidth-1:0] SeedRaw = Seed[PrsWidth-1:0];
    localparam logic [PrsWidth-1:0] One     = {{(PrsWidth-1){1'b0}}, 1'b1};
    localparam logic [PrsWidth-1:0] SeedVal = (SeedRaw == '0) ? One : SeedRaw;

    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic [PrsWidth-1:0] lfsr_q;
    logic [PrsWidth-1:0] lfsr_d;
    logic [PrsWidth-1:0] lfsr_nxt;
    logic                sense_q;
    logic                sense_d;
    logic                pulse_q;
    logic                pulse_d;
    logic                tick;

    // Prescaler countdown, Galois LFSR step and sense-clock/strobe next state
    always_comb begin
        tick     = bus.enable && (cnt_q == 8'd0);
        lfsr_nxt = {lfsr_q[PrsWidth-2:0], 1'b0}
                 ^ (lfsr_q[PrsWidth-1] ? Poly : '0);
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        sense_d  = sense_q;
        if (!bus.enable) begin
            cnt_d   = bus.div_val;
            lfsr_d  = SeedVal;
            sense_d = 1'b0;
        end else if (tick) begin
            cnt_d = bus.div_val;
            if (bus.mode) begin
                lfsr_d  = (lfsr_q == '0) ? SeedVal : lfsr_nxt;
                sense_d = lfsr_nxt[PrsWidth-1];
            end else begin
                sense_d = ~sense_q;
            end
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
        pulse_d = tick && sense_d && !sense_q;
    end

    // State registers; reset returns to idle with the LFSR at its seed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 8'd0;
            lfsr_q  <= SeedVal;
            sense_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            sense_q <= sense_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.sense_clk = sense_q;
    assign bus.pulse     = pulse_q;
    assign bus.prs_state = lfsr_q;
endmodule

// File: tb/tb_capsense_prs_pulse_gen.sv
// Bench for capsense_prs_pulse_gen: expected pulses are queued by the
// stimulus and matched by an independent pulse monitor.
module tb_capsense_prs_pulse_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    capsense_prs_if #(.PrsWidth(8))  if8 ();
    capsense_prs_if #(.PrsWidth(16)) if16 ();

    assign if16.enable  = if8.enable;
    assign if16.mode    = if8.mode;
    assign if16.div_val = if8.div_val;

    capsense_prs_pulse_gen #(
        .PrsWidth(8),
        .Polynomial(16'h0071),
        .Seed(16'h0001)
    ) dut8 (
        .clock(clock),
        .reset(reset),
        .bus(if8.slave)
    );

    capsense_prs_pulse_gen dut16 (
        .clock(clock),
        .reset(reset),
        .bus(if16.slave)
    );

    typedef struct packed {
        int         cyc;
        logic [7:0] st;
    } ev_t;

    ev_t        exp_q[$];
    int         tests     = 0;
    int         fails     = 0;
    int         cyc       = 0;
    int         pulse_cnt = 0;
    logic [7:0] seq[0:255];
    logic [7:0] hand[1:9];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic void push(int c, logic [7:0] s);
        ev_t e;
        e.cyc = c;
        e.st  = s;
        exp_q.push_back(e);
    endfunction

    function automatic logic [7:0] step8(logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h71 : 8'h00);
    endfunction

    // Pulse monitor: every strobe must match the next queued expectation
    always @(negedge clock) begin
        if (if8.pulse === 1'b1) begin
            ev_t e;
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_state", {24'd0, if8.prs_state}, {24'd0, e.st});
                check("pulse_sense", {31'd0, if8.sense_clk}, 32'd1);
            end
        end
    end

    task automatic tstep();
        @(negedge clock);
    endtask

    initial begin
        int base;
        int pc0;
        logic ex;

        hand[1] = 8'h02; hand[2] = 8'h04; hand[3] = 8'h08;
        hand[4] = 8'h10; hand[5] = 8'h20; hand[6] = 8'h40;
        hand[7] = 8'h80; hand[8] = 8'h71; hand[9] = 8'hE2;
        seq[0] = 8'h01;
        for (int k = 1; k < 256; k++) seq[k] = step8(seq[k-1]);

        if8.enable  = 1'b0;
        if8.mode    = 1'b0;
        if8.div_val = 8'd3;

        // reset and idle
        tstep();
        check("rst_sense", {31'd0, if8.sense_clk}, 32'd0);
        check("rst_prs16", {16'd0, if16.prs_state}, 32'h0001);
        tstep();
        tstep();
        reset = 1'b1;
        tstep();
        check("idle_prs8", {24'd0, if8.prs_state}, 32'h01);
        repeat (19) tstep();
        check("idle_sense", {31'd0, if8.sense_clk}, 32'd0);
        check("idle_pulse", {31'd0, if8.pulse}, 32'd0);
        check("idle_prs16", {16'd0, if16.prs_state}, 32'h0001);

        // fixed divider, div_val=3
        base = cyc;
        for (int k = 0; k < 5; k++) push(base + 4 + 8 * k, 8'h01);
        if8.enable = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tstep();
            ex = (i >= 4) && (((i - 4) % 8) < 4);
            check("fix3_sense8", {31'd0, if8.sense_clk}, {31'd0, ex});
            check("fix3_sense16", {31'd0, if16.sense_clk}, {31'd0, ex});
        end
        if8.enable = 1'b0;
        tstep();
        check("fix3_stop_sense", {31'd0, if8.sense_clk}, 32'd0);

        // minimum divider, div_val=0
        if8.div_val = 8'd0;
        tstep();
        tstep();
        base = cyc;
        pc0  = pulse_cnt;
        for (int k = 0; k < 50; k++) push(base + 1 + 2 * k, 8'h01);
        if8.enable = 1'b1;
        repeat (100) tstep();
        check("div0_pulse_count", pulse_cnt - pc0, 50);
        if8.enable = 1'b0;
        tstep();

        // PRS run of 37 ticks
        if8.mode = 1'b1;
        tstep();
        base = cyc;
        for (int k = 1; k <= 37; k++)
            if (seq[k][7] && !seq[k-1][7]) push(base + k, seq[k]);
        if8.enable = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            tstep();
            check("prs_state", {24'd0, if8.prs_state}, {24'd0, seq[k]});
            check("prs_sense", {31'd0, if8.sense_clk}, {31'd0, seq[k][7]});
            if (k <= 9)
                check("prs_hand", {24'd0, if8.prs_state}, {24'd0, hand[k]});
        end

        // single-clock stop, then replay the full sequence
        if8.enable = 1'b0;
        tstep();
        check("stop_sense", {31'd0, if8.sense_clk}, 32'd0);
        check("stop_pulse", {31'd0, if8.pulse}, 32'd0);
        check("stop_prs8", {24'd0, if8.prs_state}, 32'h01);
        check("stop_prs16", {16'd0, if16.prs_state}, 32'h0001);
        base = cyc;
        for (int k = 1; k <= 255; k++)
            if (seq[k][7] && !seq[k-1][7]) push(base + k, seq[k]);
        if8.enable = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tstep();
            check("replay_state", {24'd0, if8.prs_state}, {24'd0, seq[k]});
            check("replay_sense", {31'd0, if8.sense_clk}, {31'd0, seq[k][7]});
            if (k == 1)
                check("replay_first", {24'd0, if8.prs_state}, 32'h02);
            if (k == 1)
                check("prs16_k1", {16'd0, if16.prs_state}, 32'h0002);
            if (k == 15)
                check("prs16_k15", {16'd0, if16.prs_state}, 32'h8000);
            if (k == 16)
                check("prs16_k16", {16'd0, if16.prs_state}, 32'hA011);
            if (k == 17)
                check("prs16_k17", {16'd0, if16.prs_state}, 32'hE033);
        end
        check("prs_wrap", {24'd0, if8.prs_state}, 32'h01);
        if8.enable = 1'b0;
        tstep();

        // div_val change mid-count, then async reset between edges
        if8.mode    = 1'b0;
        if8.div_val = 8'd3;
        tstep();
        base = cyc;
        push(base + 4, 8'h01);
        push(base + 10, 8'h01);
        push(base + 14, 8'h01);
        if8.enable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tstep();
            if (i == 5) if8.div_val = 8'd1;
            if (i == 9)
                check("chg_sense9", {31'd0, if8.sense_clk}, 32'd0);
            if (i == 10)
                check("chg_sense10", {31'd0, if8.sense_clk}, 32'd1);
        end
        #2 reset = 1'b0;
        #1;
        check("async_sense", {31'd0, if8.sense_clk}, 32'd0);
        check("async_pulse", {31'd0, if8.pulse}, 32'd0);
        check("async_prs8", {24'd0, if8.prs_state}, 32'h01);
        check("async_prs16", {16'd0, if16.prs_state}, 32'h0001);
        if8.enable = 1'b0;
        tstep();
        tstep();
        reset = 1'b1;
        repeat (4) tstep();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: got %0d outstanding expected 0",
                     exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
